axis_pkt_gen: RTL
=================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter: DATA_W, 512, stream data width in bits.
REQ-002 Parameter: KEEP_W, DATA_W/8 (64), byte-enable width.
REQ-003 Parameter: GAP_CYCLES, 2, idle cycles between packets when gap insertion is compiled in.
REQ-004 Port: ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: start  in  1  one-cycle request to begin a burst.
REQ-007 Port: pkt_len  in  16  packet length in bytes, sampled on accepted start.
REQ-008 Port: pkt_count  in  16  packets per burst, sampled on accepted start.
REQ-009 Port: busy  out  1  high from accepted start until final beat accepted.
REQ-010 Port: done  out  1  one-cycle pulse at burst completion.
REQ-011 Port: m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tkeep / m_axis_tlast  out/in/out/out/out  1/1/DATA_W/KEEP_W/1  AXI4-Stream transmit side.

Function
REQ-012 The FSM SHALL have states IDLE, SEND, GAP.
REQ-013 IDLE: start accepted only in IDLE; start while busy SHALL be ignored.
REQ-014 Accepted start with pkt_len==0 or pkt_count==0 SHALL stay IDLE, no beats, done pulsed next cycle.
REQ-015 Otherwise IDLE->SEND next cycle; busy=1; pkt_idx=0, beat_idx=0.
REQ-016 Beats per packet SHALL be ceil(pkt_len/64); tlast=1 only on the final beat.
REQ-017 tkeep SHALL be all ones except the final beat: low (pkt_len mod 64) bits set, all ones when mod is 0.
REQ-018 tdata 32-bit word k (k=0..15, word 0 in bits [31:0]) SHALL be {pkt_idx[15:0], beat_idx[11:0], k[3:0]}.
REQ-019 tvalid, once asserted, SHALL remain high with tdata/tkeep/tlast stable until tready=1 (no retraction).
REQ-020 A beat transfers on tvalid&&tready; next beat SHALL be presented the following cycle (full throughput under constant tready).
REQ-021 Final beat of last packet accepted: next state IDLE, busy=0, done=1 for one cycle, tvalid=0.
REQ-022 Final beat of a non-last packet accepted: pkt_idx+1, beat_idx=0, next state GAP (macro defined) or SEND.
REQ-023 Counters SHALL be 16 bits; pkt_count=65535 SHALL complete without wrap-induced early termination.
REQ-024 Input changes on pkt_len/pkt_count during busy SHALL have no effect.

Reset
REQ-025 On ap_rst_n low, immediately: state IDLE, tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0, counters 0.
REQ-026 Reset mid-packet SHALL abort the burst; no done pulse; after release wait for new start.

Configuration
REQ-027 Macro AXIS_PKT_GEN_GAP_EN: defined -> GAP state holds tvalid=0 for exactly GAP_CYCLES cycles, then SEND; undefined -> GAP state and its counter absent, packets back-to-back.

Structure
REQ-028 Shared package axis_pkg SHALL hold DATA_W/KEEP_W defaults, the FSM state enum, and a beat struct {data, keep, last}.
REQ-029 Sub-module axis_keep_gen SHALL be used: combinational pkt_len[5:0] -> final-beat tkeep mask.
REQ-030 Output beat SHALL be registered (no combinational path tready->tdata).

Verification
REQ-031 pkt_len=128, pkt_count=1, tready=1 -> 2 beats, tkeep=all ones both, tlast on beat 1, word5 of beat1=0x00000015, done 1 cycle after.
REQ-032 pkt_len=65, pkt_count=3, tready=1, macro defined -> 6 beats, final tkeep=0x1 each packet, 2 idle cycles between packets, pkt_idx 0,1,2 in tdata[31:16].
REQ-033 pkt_len=200, tready toggling 1/0 every cycle -> tdata/tkeep/tlast stable while stalled, 4 beats, last tkeep=0xFF.
REQ-034 start with pkt_len=0 -> no tvalid, done pulse next cycle; second start mid-burst -> ignored.
REQ-035 ap_rst_n low on beat 1 of packet 2 -> tvalid=0 immediately, busy=0, no done; new start restarts at pkt_idx 0.
REQ-036 Macro undefined, pkt_len=64, pkt_count=4, tready=1 -> 4 consecutive valid cycles, tlast every beat.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet generator: default widths,
// FSM state encoding and the registered output beat.
package axis_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/axis_keep_gen.sv
// Final-beat byte-enable mask: the low (len mod 64) bytes are enabled, or
// every byte when the packet ends exactly on a beat boundary.
module axis_keep_gen #(
  parameter int KEEP_W = 64
) (
  input  logic [5:0]        len_mod,
  output logic [KEEP_W-1:0] keep
);

  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
    assign keep[gi] = (len_mod == 6'd0) || (6'(gi) < len_mod);
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream burst generator: emits pkt_count packets of pkt_len bytes with
// an indexed data pattern. Optional idle cycles between packets are compiled
// in with AXIS_PKT_GEN_GAP_EN.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int DATA_W     = AXIS_DATA_W,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [15:0]       pkt_len,
  input  logic [15:0]       pkt_count,
  output logic              busy,
  output logic              done,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast
);

  state_t      state_reg;
  logic [15:0] len_reg;
  logic [15:0] count_reg;
  logic [15:0] pkt_idx_reg;
  logic [15:0] beat_idx_reg;
  logic        tvalid_reg;
  logic        busy_reg;
  logic        done_reg;
  beat_t       beat_reg;

`ifdef AXIS_PKT_GEN_GAP_EN
  logic [15:0] gap_cnt_reg;
`endif

  logic [15:0]       eff_len;
  logic [10:0]       beats;
  logic [15:0]       last_beat_idx;
  logic [KEEP_W-1:0] final_keep;
  logic              cur_final;
  logic              cur_last_pkt;
  logic              accept;
  logic [15:0]       pkt_idx_next;
  logic [15:0]       beat_idx_next;
  logic [DATA_W-1:0] data_next;
  beat_t             beat_next;

  // In IDLE the first beat is built straight from the ports so it can be
  // registered on the same edge that accepts start.
  assign eff_len       = (state_reg == ST_IDLE) ? pkt_len : len_reg;
  assign beats         = {1'b0, eff_len[15:6]} + {10'd0, |eff_len[5:0]};
  assign last_beat_idx = {5'd0, beats} - 16'd1;
  assign cur_final     = (beat_idx_reg == last_beat_idx);
  assign cur_last_pkt  = (pkt_idx_reg == count_reg - 16'd1);
  assign accept        = tvalid_reg && m_axis_tready;

  axis_keep_gen #(
    .KEEP_W (KEEP_W)
  ) u_keep_gen (
    .len_mod (eff_len[5:0]),
    .keep    (final_keep)
  );

  always_comb begin
    pkt_idx_next  = 16'd0;
    beat_idx_next = 16'd0;
    case (state_reg)
      ST_SEND: begin
        if (cur_final) begin
          pkt_idx_next  = pkt_idx_reg + 16'd1;
          beat_idx_next = 16'd0;
        end else begin
          pkt_idx_next  = pkt_idx_reg;
          beat_idx_next = beat_idx_reg + 16'd1;
        end
      end
      ST_GAP: begin
        pkt_idx_next  = pkt_idx_reg;
        beat_idx_next = 16'd0;
      end
      default: begin
        pkt_idx_next  = 16'd0;
        beat_idx_next = 16'd0;
      end
    endcase
  end

  for (genvar gi = 0; gi < DATA_W / 32; gi++) begin : g_word
    assign data_next[32*gi +: 32] = {pkt_idx_next, beat_idx_next[11:0], 4'(gi)};
  end

  always_comb begin
    beat_next      = '0;
    beat_next.data = data_next;
    beat_next.last = (beat_idx_next == last_beat_idx);
    beat_next.keep = beat_next.last ? final_keep : '1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= 16'd0;
      count_reg    <= 16'd0;
      pkt_idx_reg  <= 16'd0;
      beat_idx_reg <= 16'd0;
      tvalid_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      beat_reg     <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_cnt_reg  <= 16'd0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (pkt_len == 16'd0 || pkt_count == 16'd0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg    <= ST_SEND;
              busy_reg     <= 1'b1;
              len_reg      <= pkt_len;
              count_reg    <= pkt_count;
              pkt_idx_reg  <= 16'd0;
              beat_idx_reg <= 16'd0;
              tvalid_reg   <= 1'b1;
              beat_reg     <= beat_next;
            end
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (cur_final && cur_last_pkt) begin
              state_reg  <= ST_IDLE;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              tvalid_reg <= 1'b0;
              beat_reg   <= '0;
            end else if (cur_final) begin
              pkt_idx_reg  <= pkt_idx_next;
              beat_idx_reg <= 16'd0;
`ifdef AXIS_PKT_GEN_GAP_EN
              state_reg    <= ST_GAP;
              tvalid_reg   <= 1'b0;
              gap_cnt_reg  <= 16'd0;
`else
              beat_reg     <= beat_next;
`endif
            end else begin
              beat_idx_reg <= beat_idx_next;
              beat_reg     <= beat_next;
            end
          end
        end
`ifdef AXIS_PKT_GEN_GAP_EN
        ST_GAP: begin
          if (int'(gap_cnt_reg) + 1 >= GAP_CYCLES) begin
            state_reg  <= ST_SEND;
            tvalid_reg <= 1'b1;
            beat_reg   <= beat_next;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = beat_reg.data;
  assign m_axis_tkeep  = beat_reg.keep;
  assign m_axis_tlast  = beat_reg.last;

endmodule
